// File: rtl/llbit_reservation_unit_pkg.sv
// Shared configuration and types for the LL/SC reservation tracker.
package llbit_reservation_unit_pkg;

    localparam int unsigned LLBIT_GRANULE_BYTES  = 16;
    localparam int unsigned LLBIT_TIMEOUT_CYCLES = 1024;

    typedef enum logic {
        IDLE     = 1'b0,
        RESERVED = 1'b1
    } llbit_state_t;

    // Counter must be able to hold TIMEOUT_CYCLES itself (saturation value).
    function automatic int unsigned llbit_cnt_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/llbit_timeout_counter.sv
// Saturating forward-progress counter; expired_o is raised on the last cycle before timeout.
module llbit_timeout_counter
    import llbit_reservation_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LLBIT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = llbit_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SAT_VAL    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] EXPIRE_VAL = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (clear_i) begin
            w_count_next = '0;
        end else if (enable_i && (r_count != SAT_VAL)) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (r_count == EXPIRE_VAL);

endmodule

// File: rtl/llbit_reservation_unit.sv
// LLbit / reserved-granule tracker fed by the in-order commit bundle.
module llbit_reservation_unit
    import llbit_reservation_unit_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned PADDR_WIDTH    = 32,
    parameter int unsigned GRANULE_BYTES  = LLBIT_GRANULE_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = LLBIT_TIMEOUT_CYCLES
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [COMMIT_WIDTH-1:0]                      commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]                      commit_is_ll_i,
    input  logic [COMMIT_WIDTH-1:0]                      commit_is_sc_i,
    input  logic [COMMIT_WIDTH*PADDR_WIDTH-1:0]          commit_paddr_i,
    input  logic                                         snoop_inv_valid_i,
    input  logic [PADDR_WIDTH-1:0]                       snoop_inv_paddr_i,
    input  logic                                         csr_wcllb_i,
    input  logic                                         ertn_i,
    input  logic                                         csr_klo_i,
    output logic [COMMIT_WIDTH-1:0]                      sc_success_o,
    output logic                                         klo_consume_o,
    output logic                                         llbit_o,
    output logic [PADDR_WIDTH-$clog2(GRANULE_BYTES)-1:0] resv_granule_o
);

    localparam int unsigned GRAN_LSB = $clog2(GRANULE_BYTES);
    localparam int unsigned GW       = PADDR_WIDTH - GRAN_LSB;

    llbit_state_t                     r_state;
    llbit_state_t                     w_state_next;
    logic [GW-1:0]                    r_granule;
    logic [GW-1:0]                    w_granule_next;
    logic [GW-1:0]                    w_snoop_granule;
    logic                             w_llbit_run;
    logic                             w_any_ll;
    logic                             w_expired;
    logic                             w_cnt_clear;
    logic                             w_cnt_en;
    logic [COMMIT_WIDTH*GRAN_LSB-1:0] w_unused_low;
    logic                             w_unused;

    assign w_snoop_granule = snoop_inv_paddr_i[PADDR_WIDTH-1:GRAN_LSB];

    // Slot chain: pre-clears act on the start-of-cycle state, then slots 0..N-1 in order.
    always_comb begin
        w_llbit_run    = (r_state == RESERVED);
        w_granule_next = r_granule;
        w_any_ll       = 1'b0;
        klo_consume_o  = 1'b0;
        sc_success_o   = '0;

        if (csr_wcllb_i || (snoop_inv_valid_i && (w_snoop_granule == r_granule)) ||
            w_expired || (ertn_i && !csr_klo_i)) begin
            w_llbit_run = 1'b0;
        end
        if (ertn_i && csr_klo_i) begin
            klo_consume_o = 1'b1;
        end

        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid_i[i]) begin
                if (commit_is_ll_i[i]) begin
                    w_llbit_run    = 1'b1;
                    w_granule_next = commit_paddr_i[i*PADDR_WIDTH+GRAN_LSB +: GW];
                    w_any_ll       = 1'b1;
                end else if (commit_is_sc_i[i]) begin
                    // No granule compare: any SC consumes the LLbit.
                    sc_success_o[i] = w_llbit_run;
                    w_llbit_run     = 1'b0;
                end
            end
        end

        w_state_next = w_llbit_run ? RESERVED : IDLE;
    end

    assign w_cnt_clear = w_any_ll || (w_state_next == IDLE);
    assign w_cnt_en    = (r_state == RESERVED);

    llbit_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (w_cnt_clear),
        .enable_i (w_cnt_en),
        .expired_o(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_granule <= '0;
        end else begin
            r_state   <= w_state_next;
            r_granule <= w_granule_next;
        end
    end

    assign llbit_o        = (r_state == RESERVED);
    assign resv_granule_o = r_granule;

    // Byte offsets within a granule never matter.
    always_comb begin
        w_unused_low = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_unused_low[i*GRAN_LSB +: GRAN_LSB] = commit_paddr_i[i*PADDR_WIDTH +: GRAN_LSB];
        end
    end
    assign w_unused = ^{w_unused_low, snoop_inv_paddr_i[GRAN_LSB-1:0]};

endmodule

// File: tb/tb_llbit_reservation_unit.sv
// Scoreboard bench for llbit_reservation_unit (2 slots, 16-byte granule, timeout of 4 cycles).
module tb_llbit_reservation_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  commit_valid_i;
    logic [1:0]  commit_is_ll_i;
    logic [1:0]  commit_is_sc_i;
    logic [63:0] commit_paddr_i;
    logic        snoop_inv_valid_i;
    logic [31:0] snoop_inv_paddr_i;
    logic        csr_wcllb_i;
    logic        ertn_i;
    logic        csr_klo_i;
    logic [1:0]  sc_success_o;
    logic        klo_consume_o;
    logic        llbit_o;
    logic [27:0] resv_granule_o;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  ll;
        logic [1:0]  sc;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        sv;
        logic [31:0] sa;
        logic        wc;
        logic        er;
        logic        kl;
        logic [1:0]  e_sc;
        logic        e_klo;
        logic        e_ll;
    } stim_t;

    typedef struct packed {
        logic [1:0] sc;
        logic       klo;
        logic       ll;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    llbit_reservation_unit #(
        .COMMIT_WIDTH  (2),
        .PADDR_WIDTH   (32),
        .GRANULE_BYTES (16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .commit_valid_i   (commit_valid_i),
        .commit_is_ll_i   (commit_is_ll_i),
        .commit_is_sc_i   (commit_is_sc_i),
        .commit_paddr_i   (commit_paddr_i),
        .snoop_inv_valid_i(snoop_inv_valid_i),
        .snoop_inv_paddr_i(snoop_inv_paddr_i),
        .csr_wcllb_i      (csr_wcllb_i),
        .ertn_i           (ertn_i),
        .csr_klo_i        (csr_klo_i),
        .sc_success_o     (sc_success_o),
        .klo_consume_o    (klo_consume_o),
        .llbit_o          (llbit_o),
        .resv_granule_o   (resv_granule_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [1:0] v, input logic [1:0] ll, input logic [1:0] sc,
                                 input logic [31:0] a0, input logic [31:0] a1, input logic sv,
                                 input logic [31:0] sa, input logic wc, input logic er,
                                 input logic kl, input logic [1:0] e_sc, input logic e_klo,
                                 input logic e_ll);
        stim_t s;
        s.v = v; s.ll = ll; s.sc = sc; s.a0 = a0; s.a1 = a1; s.sv = sv; s.sa = sa;
        s.wc = wc; s.er = er; s.kl = kl; s.e_sc = e_sc; s.e_klo = e_klo; s.e_ll = e_ll;
        return s;
    endfunction

    task automatic set_idle();
        commit_valid_i    = '0;
        commit_is_ll_i    = '0;
        commit_is_sc_i    = '0;
        commit_paddr_i    = '0;
        snoop_inv_valid_i = 1'b0;
        snoop_inv_paddr_i = '0;
        csr_wcllb_i       = 1'b0;
        ertn_i            = 1'b0;
        csr_klo_i         = 1'b0;
    endtask

    // Drive one cycle of stimulus on the falling edge and record what it must produce.
    task automatic run(input stim_t s);
        exp_t e;
        @(negedge clk);
        commit_valid_i    = s.v;
        commit_is_ll_i    = s.ll;
        commit_is_sc_i    = s.sc;
        commit_paddr_i    = {s.a1, s.a0};
        snoop_inv_valid_i = s.sv;
        snoop_inv_paddr_i = s.sa;
        csr_wcllb_i       = s.wc;
        ertn_i            = s.er;
        csr_klo_i         = s.kl;
        e.sc = s.e_sc; e.klo = s.e_klo; e.ll = s.e_ll;
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #3;
        checks++;
        if (llbit_o !== 1'b0 || resv_granule_o !== 28'h0) begin
            errors++;
            $display("FAIL reset state: llbit=%b granule=%h want 0/0", llbit_o, resv_granule_o);
        end
        checks++;
        if (sc_success_o !== 2'b00 || klo_consume_o !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: sc=%b klo=%b want 00/0", sc_success_o, klo_consume_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        stim_t tbl[2];
        exp_t  e;
        tbl[0] = mk(2'b01, 2'b01, 2'b00, 32'h1000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[1] = mk(2'b01, 2'b00, 2'b01, 32'h1000, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 2; k++) begin
            run(tbl[k]);
            e = sb.pop_front();
            checks++;
            if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                errors++;
                $display("FAIL basic[%0d] sc/klo: got %b want %b", k,
                         {sc_success_o, klo_consume_o}, {e.sc, e.klo});
            end
            @(posedge clk);
            #1;
            checks++;
            if (llbit_o !== e.ll) begin
                errors++;
                $display("FAIL basic[%0d] llbit: got %b want %b", k, llbit_o, e.ll);
            end
            if (k == 0) begin
                checks++;
                if (resv_granule_o !== 28'h100) begin
                    errors++;
                    $display("FAIL basic granule: got %h want %h", resv_granule_o, 28'h100);
                end
            end
        end
    endtask

    task automatic test_snoop();
        stim_t tbl[9];
        exp_t  e;
        tbl[0] = mk(2'b01, 2'b01, 2'b00, 32'h1000, 0, 0, 0,        0, 0, 0, 2'b00, 0, 1);
        tbl[1] = mk(2'b00, 2'b00, 2'b00, 0,        0, 1, 32'h100C, 0, 0, 0, 2'b00, 0, 0);
        tbl[2] = mk(2'b01, 2'b00, 2'b01, 32'h1000, 0, 0, 0,        0, 0, 0, 2'b00, 0, 0);
        tbl[3] = mk(2'b01, 2'b01, 2'b00, 32'h1000, 0, 0, 0,        0, 0, 0, 2'b00, 0, 1);
        tbl[4] = mk(2'b00, 2'b00, 2'b00, 0,        0, 1, 32'h1010, 0, 0, 0, 2'b00, 0, 1);
        tbl[5] = mk(2'b01, 2'b00, 2'b01, 32'h5000, 0, 0, 0,        0, 0, 0, 2'b01, 0, 0);
        tbl[6] = mk(2'b01, 2'b01, 2'b00, 32'h3000, 0, 0, 0,        0, 0, 0, 2'b00, 0, 1);
        tbl[7] = mk(2'b01, 2'b01, 2'b00, 32'h3000, 0, 1, 32'h3004, 0, 0, 0, 2'b00, 0, 1);
        tbl[8] = mk(2'b01, 2'b00, 2'b01, 32'h3000, 0, 0, 0,        0, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 9; k++) begin
            run(tbl[k]);
            e = sb.pop_front();
            checks++;
            if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                errors++;
                $display("FAIL snoop[%0d] sc/klo: got %b want %b", k,
                         {sc_success_o, klo_consume_o}, {e.sc, e.klo});
            end
            @(posedge clk);
            #1;
            checks++;
            if (llbit_o !== e.ll) begin
                errors++;
                $display("FAIL snoop[%0d] llbit: got %b want %b", k, llbit_o, e.ll);
            end
        end
    endtask

    task automatic test_bundle();
        stim_t tbl[8];
        exp_t  e;
        tbl[0] = mk(2'b11, 2'b01, 2'b10, 32'h2000, 32'h2000, 0, 0, 0, 0, 0, 2'b10, 0, 0);
        tbl[1] = mk(2'b01, 2'b01, 2'b00, 32'h2000, 0,        0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[2] = mk(2'b11, 2'b00, 2'b11, 32'h2000, 32'h2000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        tbl[3] = mk(2'b11, 2'b10, 2'b01, 32'h2000, 32'h4000, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[4] = mk(2'b10, 2'b00, 2'b10, 0,        32'h4000, 0, 0, 0, 0, 0, 2'b10, 0, 0);
        tbl[5] = mk(2'b01, 2'b01, 2'b00, 32'h4000, 0,        0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[6] = mk(2'b00, 2'b00, 2'b11, 32'h4000, 32'h4000, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[7] = mk(2'b01, 2'b00, 2'b01, 32'h4000, 0,        0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 8; k++) begin
            run(tbl[k]);
            e = sb.pop_front();
            checks++;
            if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                errors++;
                $display("FAIL bundle[%0d] sc/klo: got %b want %b", k,
                         {sc_success_o, klo_consume_o}, {e.sc, e.klo});
            end
            @(posedge clk);
            #1;
            checks++;
            if (llbit_o !== e.ll) begin
                errors++;
                $display("FAIL bundle[%0d] llbit: got %b want %b", k, llbit_o, e.ll);
            end
        end
    endtask

    task automatic test_wcllb();
        stim_t tbl[6];
        exp_t  e;
        tbl[0] = mk(2'b01, 2'b01, 2'b00, 32'h6000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[1] = mk(2'b00, 2'b00, 2'b00, 0,        0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
        tbl[2] = mk(2'b01, 2'b01, 2'b00, 32'h6000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[3] = mk(2'b01, 2'b01, 2'b00, 32'h6000, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1);
        tbl[4] = mk(2'b01, 2'b00, 2'b01, 32'h6000, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
        tbl[5] = mk(2'b00, 2'b00, 2'b00, 0,        0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run(tbl[k]);
            e = sb.pop_front();
            checks++;
            if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                errors++;
                $display("FAIL wcllb[%0d] sc/klo: got %b want %b", k,
                         {sc_success_o, klo_consume_o}, {e.sc, e.klo});
            end
            @(posedge clk);
            #1;
            checks++;
            if (llbit_o !== e.ll) begin
                errors++;
                $display("FAIL wcllb[%0d] llbit: got %b want %b", k, llbit_o, e.ll);
            end
        end
    endtask

    task automatic test_ertn();
        stim_t tbl[6];
        exp_t  e;
        tbl[0] = mk(2'b01, 2'b01, 2'b00, 32'h7000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[1] = mk(2'b00, 2'b00, 2'b00, 0,        0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        tbl[2] = mk(2'b01, 2'b01, 2'b00, 32'h7000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[3] = mk(2'b00, 2'b00, 2'b00, 0,        0, 0, 0, 0, 1, 1, 2'b00, 1, 1);
        tbl[4] = mk(2'b00, 2'b00, 2'b00, 0,        0, 0, 0, 0, 0, 1, 2'b00, 0, 1);
        tbl[5] = mk(2'b01, 2'b00, 2'b01, 32'h7000, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run(tbl[k]);
            e = sb.pop_front();
            checks++;
            if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                errors++;
                $display("FAIL ertn[%0d] sc/klo: got %b want %b", k,
                         {sc_success_o, klo_consume_o}, {e.sc, e.klo});
            end
            @(posedge clk);
            #1;
            checks++;
            if (llbit_o !== e.ll) begin
                errors++;
                $display("FAIL ertn[%0d] llbit: got %b want %b", k, llbit_o, e.ll);
            end
        end
    endtask

    // Step i is cycle i; pass 0 has one LL at cycle 0, pass 1 adds a second LL at cycle 3.
    task automatic test_timeout();
        exp_t  e;
        logic  is_ll;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 9; i++) begin
                is_ll = (i == 0) || (pass == 1 && i == 3);
                run(mk(is_ll ? 2'b01 : 2'b00, is_ll ? 2'b01 : 2'b00, 2'b00, 32'h8000, 0,
                       0, 0, 0, 0, 0, 2'b00, 0, (pass == 0) ? (i < 4) : (i < 7)));
                e = sb.pop_front();
                checks++;
                if ({sc_success_o, klo_consume_o} !== {e.sc, e.klo}) begin
                    errors++;
                    $display("FAIL timeout p%0d c%0d sc/klo: got %b want %b", pass, i,
                             {sc_success_o, klo_consume_o}, {e.sc, e.klo});
                end
                @(posedge clk);
                #1;
                checks++;
                if (llbit_o !== e.ll) begin
                    errors++;
                    $display("FAIL timeout p%0d cycle %0d llbit: got %b want %b", pass, i + 1,
                             llbit_o, e.ll);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        run(mk(2'b01, 2'b01, 2'b00, 32'h9000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        e = sb.pop_front();
        @(posedge clk);
        #1;
        checks++;
        if (llbit_o !== e.ll) begin
            errors++;
            $display("FAIL reset_mid setup llbit: got %b want %b", llbit_o, e.ll);
        end
        @(negedge clk);
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (llbit_o !== 1'b0 || resv_granule_o !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid async: llbit=%b granule=%h want 0/0", llbit_o, resv_granule_o);
        end
        @(negedge clk);
        rst_n          = 1'b1;
        commit_valid_i = 2'b01;
        commit_is_sc_i = 2'b01;
        commit_paddr_i = {32'h0, 32'h9000};
        #1;
        checks++;
        if (sc_success_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid first SC: got %b want %b", sc_success_o, 2'b00);
        end
        @(posedge clk);
        #1;
        checks++;
        if (llbit_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid llbit after SC: got %b want 0", llbit_o);
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snoop();
        test_bundle();
        test_wcllb();
        test_ertn();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/llbit_reservation_unit.md
# llbit_reservation_unit

Multi-slot LL/SC reservation tracker for the commit stage. Holds the LLbit and the reserved physical granule, and updates them from up to COMMIT_WIDTH in-order committing instructions per cycle. Clears the reservation on external snoop invalidation, CSR LLBCTL.WCLLB, ERTN (honouring KLO) and an optional forward-progress timeout. Gives each committing SC.W its success bit, which the commit stage uses as the rd write data and as the store enable.

## Interface
- COMMIT_WIDTH, 2, commit slots per cycle; slot 0 is oldest.
- PADDR_WIDTH, 32, physical address width.
- GRANULE_BYTES, 16, reservation granule; power of two, ≥4.
- TIMEOUT_CYCLES, 1024, cycles in RESERVED before auto-clear; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- commit_valid_i  in  COMMIT_WIDTH  slot commits this cycle
- commit_is_ll_i  in  COMMIT_WIDTH  slot is LL.W
- commit_is_sc_i  in  COMMIT_WIDTH  slot is SC.W
- commit_paddr_i  in  COMMIT_WIDTH*PADDR_WIDTH  slot physical address; slot i is at bits [i*PADDR_WIDTH +: PADDR_WIDTH]
- snoop_inv_valid_i  in  1  external write/invalidate observed
- snoop_inv_paddr_i  in  PADDR_WIDTH  snoop address
- csr_wcllb_i  in  1  CSR write of LLBCTL.WCLLB=1
- ertn_i  in  1  ERTN commits; never concurrent with commit_valid_i≠0
- csr_klo_i  in  1  current LLBCTL.KLO
- sc_success_o  out  COMMIT_WIDTH  per-slot SC result, combinational
- klo_consume_o  out  1  pulse: ERTN kept LLbit; CSR unit clears KLO
- llbit_o  out  1  registered LLbit, for CSR LLBCTL.ROLLB reads
- resv_granule_o  out  PADDR_WIDTH-log2(GRANULE_BYTES)  registered reserved granule

## Operation
- State FSM: IDLE (llbit=0) and RESERVED (llbit=1).
- Reset: IDLE, llbit_o=0, resv_granule_o=0, timeout counter=0, klo_consume_o=0.
- Granule match: paddr[PADDR_WIDTH-1:log2(GRANULE_BYTES)] equals the stored granule.
- Per-cycle evaluation order:
  1. Pre-clear. Clear the start-of-cycle reservation if any of these holds: csr_wcllb_i; snoop_inv_valid_i with a granule match; the timeout has expired; ertn_i with csr_klo_i=0.
  2. KLO case. ertn_i with csr_klo_i=1 keeps the reservation and asserts klo_consume_o for that cycle.
  3. Commit slots, processed 0..COMMIT_WIDTH-1 against the running state.
     - LL: set llbit, load the slot granule, zero the counter.
     - SC: sc_success_o[i] = running llbit. The reservation granule is not compared (LoongArch semantics). Any SC then clears the running llbit, success or not.
- sc_success_o[i]=0 for a slot that is invalid or not an SC.
- LL and SC in one bundle: LL in slot 0 then SC in slot 1 → SC succeeds.
- A snoop in the same cycle as a later LL: the LL re-establishes the reservation (LL wins).
- The end-of-cycle running state is registered.

## Timing
- sc_success_o is combinational from the registered state plus same-cycle inputs; zero-cycle latency.
- llbit_o and resv_granule_o update on the clock edge after the event.
- Timeout counter:
  - increments each cycle in RESERVED and saturates at TIMEOUT_CYCLES;
  - expires when it equals TIMEOUT_CYCLES-1 at the start of a cycle, so the reservation clears after exactly TIMEOUT_CYCLES full cycles;
  - zeroes on every LL and in IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1); 1 bit when TIMEOUT_CYCLES=0.
- Reset asserted mid-sequence forces IDLE immediately (asynchronous). No SC succeeds in the first cycle after reset release.

## Structure
- core_config: add LLBIT_GRANULE_BYTES and LLBIT_TIMEOUT_CYCLES.
- core_types: add typedef llbit_state_t (IDLE, RESERVED).
- Sub-module llbit_timeout_counter: saturating counter with clear, enable and an expired output.
- Top level: the slot-ordered combinational chain plus the state registers.

## Test plan
- Basic pair: LL 0x1000 in slot 0, next cycle SC in slot 0 → sc_success_o=01; llbit_o 1 then 0.
- Snoop hit vs miss: after LL 0x1000, snoop 0x100C (same 16-byte granule) → llbit_o=0 and a later SC fails. Snoop 0x1010 → reservation kept.
- Same-bundle ordering:
  - {slot0 LL 0x2000, slot1 SC} → sc_success_o=10.
  - {slot0 SC, slot1 SC} while RESERVED → 01.
- ERTN:
  - ertn_i with KLO=0 in RESERVED → llbit_o=0, klo_consume_o=0.
  - ertn_i with KLO=1 → llbit_o stays 1, klo_consume_o=1 for one cycle.
- Timeout (TIMEOUT_CYCLES=4): LL at cycle 0 → llbit_o=1 for cycles 1–4, 0 at cycle 5. A second LL at cycle 3 extends this to cycle 8.
- Reset mid-reservation: drop rst_n while RESERVED → llbit_o=0 asynchronously. After release, SC → sc_success_o=0.
